knn_ctrl: RTL and testbench
===========================

Name: knn_ctrl

Overview:
- Sequencer for knn_core. On start, for each test point it clears the neighbour list and fetches the test point into operand A.
- It then streams every data point into operand B at one per cycle. After the pipeline drains, it captures knn_info as one result word.
- Sits between a synchronous point memory (shared with the host) and knn_core. The host sees only start/busy/done and a result handshake.

Parameters:
- DATA_W, 32, point word width (packed coordinates), matches knn_core A/B.
- NBR_TESTP, 4, number of test points per run.
- NBR_DATAP, 10, number of data points per test point, minimum 1.
- ADDR_W, 8, point memory address width; NBR_TESTP+NBR_DATAP <= 2^ADDR_W.
- DIST_LAT, 3, cycles from core_valid to the list being updated inside knn_core.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- start  in  1  one-cycle run request, honoured only in IDLE.
- busy  out  1  high from the cycle after accepted start until DONE.
- done  out  1  one-cycle pulse when the last result is acknowledged.
- mem_req  out  1  read strobe to point memory.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_req.
- core_en  out  1  knn_core en, high while busy.
- core_clr  out  1  one-cycle list clear, ORed into the knn_core list reset by the integrator.
- core_valid  out  1  operand pair valid, one cycle per data point.
- core_ready  out  1  knn_core distance enable, high in STREAM and DRAIN.
- core_A  out  DATA_W  registered test point.
- core_B  out  DATA_W  registered data point.
- core_info  in  8  knn_core result.
- res_valid  out  1  result available.
- res_idx  out  $clog2(NBR_TESTP)  test point index of the result.
- res_data  out  8  captured core_info.
- res_ack  in  1  result consumed when res_valid&&res_ack.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, core_A/core_B 0.
- Memory map: test point t is at address t; data point d is at address NBR_TESTP+d.
- FSM states:
  - IDLE: on start, go to CLR; tcnt=0.
  - CLR: core_clr=1 for one cycle, then LD_T.
  - LD_T: mem_req=1, mem_addr=tcnt, then WT_T.
  - WT_T: core_A<=mem_rdata, dcnt=0, then STREAM.
  - STREAM: mem_req=1, mem_addr=NBR_TESTP+dcnt, dcnt++ each cycle. After the issue with dcnt=NBR_DATAP-1, go to DRAIN.
    - Registered core_B<=mem_rdata and core_valid=1 follow each issue by exactly 1 cycle. NBR_DATAP consecutive valid cycles result.
  - DRAIN: count DIST_LAT+1 cycles after the last core_valid, then RES. No mem_req in DRAIN.
  - RES: on entry, res_data<=core_info, res_idx<=tcnt, res_valid=1. Hold all three stable until res_ack.
    - On ack, clear res_valid the next cycle. If tcnt==NBR_TESTP-1, go to DONE; else tcnt++ and go to CLR.
    - res_ack sampled in the same cycle res_valid rises counts. res_ack without res_valid is ignored.
  - DONE: done=1 for one cycle, busy drops, return to IDLE. start in DONE is ignored; start in IDLE the following cycle is accepted.
- start while busy is ignored (no restart, no queueing).
- Per-test-point latency with immediate ack: 1 (CLR) + 2 (LD_T/WT_T) + NBR_DATAP + 1 + (DIST_LAT+1) + 1 (RES) cycles.
- Asynchronous reset mid-run returns to IDLE immediately and drops res_valid/core_valid. Any partial result is discarded; the host must re-issue start.
- Counters saturate-free: widths are $clog2 of their max+1, and wrap never occurs because transitions occur on compare.

Decomposition:
- Shared knn package: FSM state encoding (IDLE, CLR, LD_T, WT_T, STREAM, DRAIN, RES, DONE), point memory base-offset constants, result width 8.
- One natural sub-module: knn_ctrl_fetch, covering the memory issue/return alignment (mem_req -> 1-cycle-delayed core_valid/core_B register). The FSM stays in knn_ctrl.

Test Plan:
- Defaults, immediate ack; memory holds test points 0..3 and data 10 words; stub core_info=8'h5A. Expect:
  - 10 consecutive core_valid per test point;
  - res_valid 5 cycles after the last valid;
  - results idx 0..3 all 5A;
  - done 1 cycle after the 4th ack;
  - 4*(1+2+10+1+4+1)=76 cycles from start to done.
- Delay res_ack by 7 cycles on test point 1: res_data/res_idx=1 held stable for all 7 cycles, no core_clr/mem_req during the wait, run resumes at CLR for idx 2.
- start pulsed in STREAM and in DONE: no effect; a start 1 cycle after done begins a second run (core_clr seen).
- NBR_DATAP=1, NBR_TESTP=1: exactly one core_valid carrying core_B=mem[1], one result, done.
- rst=0 asserted during DRAIN of test point 2: all outputs 0 asynchronously; after release, IDLE and busy=0; a fresh start restarts at test point 0.
- Check core_A equals mem[t] and core_B sequence equals mem[4..13] for each t; core_ready high exactly over STREAM+DRAIN.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared definitions for the knn sequencer: FSM encoding, point memory layout
// and counter sizing.
package knn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LD_T,
        S_WT_T,
        S_STREAM,
        S_DRAIN,
        S_RES,
        S_DONE
    } state_t;

    localparam int TEST_BASE = 0;
    localparam int RES_W     = 8;

    // Counter/index width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Data points sit directly after the test points.
    function automatic int data_base(input int nbr_testp);
        return TEST_BASE + nbr_testp;
    endfunction

endpackage

// File: rtl/knn_ctrl_fetch.sv
// Aligns data point reads with knn_core: core_valid follows each memory issue by
// one cycle, and core_B is held stable once the stream stops.
module knn_ctrl_fetch #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_issue,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_valid <= i_issue;
            if (r_valid) begin
                r_hold <= i_mem_rdata;
            end
        end
    end

    // The memory output register is the pipeline stage on valid cycles.
    assign o_valid = r_valid;
    assign o_data  = r_valid ? i_mem_rdata : r_hold;

endmodule

// File: rtl/knn_ctrl.sv
// Sequencer for knn_core: per test point clears the list, loads operand A,
// streams all data points into operand B, drains the pipe and hands back a result.
module knn_ctrl
    import knn_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NBR_TESTP = 4,
    parameter int NBR_DATAP = 10,
    parameter int ADDR_W    = 8,
    parameter int DIST_LAT  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          core_en,
    output logic                          core_clr,
    output logic                          core_valid,
    output logic                          core_ready,
    output logic [DATA_W-1:0]             core_A,
    output logic [DATA_W-1:0]             core_B,
    input  logic [RES_W-1:0]              core_info,
    output logic                          res_valid,
    output logic [cnt_w(NBR_TESTP)-1:0]   res_idx,
    output logic [RES_W-1:0]              res_data,
    input  logic                          res_ack
);

    localparam int TW    = cnt_w(NBR_TESTP);
    localparam int DW    = cnt_w(NBR_DATAP);
    localparam int WW    = cnt_w(DIST_LAT + 2);
    localparam int DBASE = data_base(NBR_TESTP);

    localparam logic [TW-1:0] T_LAST = TW'(NBR_TESTP - 1);
    localparam logic [DW-1:0] D_LAST = DW'(NBR_DATAP - 1);
    localparam logic [WW-1:0] W_LAST = WW'(DIST_LAT + 1);

    state_t             r_state;
    state_t             w_next;
    logic [TW-1:0]      r_tcnt;
    logic [DW-1:0]      r_dcnt;
    logic [WW-1:0]      r_wcnt;
    logic [DATA_W-1:0]  r_core_a;
    logic               r_res_valid;
    logic [TW-1:0]      r_res_idx;
    logic [RES_W-1:0]   r_res_data;
    logic               w_mem_req;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic               w_issue;

    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_mem_addr = '0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CLR;
            S_CLR:    w_next = S_LD_T;
            S_LD_T: begin
                w_mem_req  = 1'b1;
                w_mem_addr = ADDR_W'(TEST_BASE) + ADDR_W'(r_tcnt);
                w_next     = S_WT_T;
            end
            S_WT_T:   w_next = S_STREAM;
            S_STREAM: begin
                w_mem_req  = 1'b1;
                w_mem_addr = ADDR_W'(DBASE) + ADDR_W'(r_dcnt);
                if (r_dcnt == D_LAST) w_next = S_DRAIN;
            end
            // Covers the last valid cycle plus DIST_LAT+1 cycles of core latency.
            S_DRAIN:  if (r_wcnt == W_LAST) w_next = S_RES;
            S_RES: begin
                if (r_res_valid && res_ack) begin
                    w_next = (r_tcnt == T_LAST) ? S_DONE : S_CLR;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            r_dcnt      <= '0;
            r_wcnt      <= '0;
            r_core_a    <= '0;
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_data  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE:   if (start) r_tcnt <= '0;
                S_WT_T: begin
                    r_core_a <= mem_rdata;
                    r_dcnt   <= '0;
                end
                S_STREAM: begin
                    if (r_dcnt == D_LAST) r_wcnt <= '0;
                    else                  r_dcnt <= r_dcnt + DW'(1);
                end
                S_DRAIN: begin
                    if (r_wcnt == W_LAST) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= core_info;
                        r_res_idx   <= r_tcnt;
                    end else begin
                        r_wcnt <= r_wcnt + WW'(1);
                    end
                end
                S_RES: begin
                    if (r_res_valid && res_ack) begin
                        r_res_valid <= 1'b0;
                        if (r_tcnt != T_LAST) r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_issue = (r_state == S_STREAM);

    knn_ctrl_fetch #(
        .DATA_W (DATA_W)
    ) u_fetch (
        .clk         (clk),
        .rst         (rst),
        .i_issue     (w_issue),
        .i_mem_rdata (mem_rdata),
        .o_valid     (core_valid),
        .o_data      (core_B)
    );

    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign core_en    = busy;
    assign core_clr   = (r_state == S_CLR);
    assign core_ready = (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign mem_req    = w_mem_req;
    assign mem_addr   = w_mem_addr;
    assign core_A     = r_core_a;
    assign res_valid  = r_res_valid;
    assign res_idx    = r_res_idx;
    assign res_data   = r_res_data;

endmodule

// File: tb/tb_knn_ctrl.sv
// Bench for knn_ctrl: a default instance and a 1x1 instance, each against a
// behavioural point memory and a cycle timeline derived from the latency rules.
`timescale 1ns/1ps
module tb_knn_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DL     = 3;
    localparam int T0     = 4;
    localparam int N0     = 10;
    localparam int PER0   = 1 + 2 + N0 + 1 + (DL + 1) + 1;
    localparam int T1     = 1;
    localparam int N1     = 1;
    localparam int PER1   = 1 + 2 + N1 + 1 + (DL + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // ---------------- DUT0 (defaults) ----------------
    logic              d0_start = 1'b0;
    logic              d0_busy, d0_done, d0_mem_req;
    logic [ADDR_W-1:0] d0_mem_addr;
    logic [DATA_W-1:0] d0_mem_rdata = '0;
    logic              d0_core_en, d0_core_clr, d0_core_valid, d0_core_ready;
    logic [DATA_W-1:0] d0_core_A, d0_core_B;
    logic [7:0]        d0_core_info = 8'h5A;
    logic              d0_res_valid;
    logic [1:0]        d0_res_idx;
    logic [7:0]        d0_res_data;
    logic              d0_res_ack = 1'b0;
    logic [DATA_W-1:0] mem0 [T0+N0];

    knn_ctrl #(.DATA_W(DATA_W), .NBR_TESTP(T0), .NBR_DATAP(N0), .ADDR_W(ADDR_W), .DIST_LAT(DL)) u_dut0 (
        .clk(clk), .rst(rst), .start(d0_start), .busy(d0_busy), .done(d0_done),
        .mem_req(d0_mem_req), .mem_addr(d0_mem_addr), .mem_rdata(d0_mem_rdata),
        .core_en(d0_core_en), .core_clr(d0_core_clr), .core_valid(d0_core_valid),
        .core_ready(d0_core_ready), .core_A(d0_core_A), .core_B(d0_core_B),
        .core_info(d0_core_info), .res_valid(d0_res_valid), .res_idx(d0_res_idx),
        .res_data(d0_res_data), .res_ack(d0_res_ack)
    );

    always @(posedge clk) begin
        if (d0_mem_req && int'(d0_mem_addr) < T0 + N0) d0_mem_rdata <= mem0[d0_mem_addr];
    end

    // ---------------- DUT1 (one test point, one data point) ----------------
    logic              d1_start = 1'b0;
    logic              d1_busy, d1_done, d1_mem_req;
    logic [ADDR_W-1:0] d1_mem_addr;
    logic [DATA_W-1:0] d1_mem_rdata = '0;
    logic              d1_core_en, d1_core_clr, d1_core_valid, d1_core_ready;
    logic [DATA_W-1:0] d1_core_A, d1_core_B;
    logic [7:0]        d1_core_info = 8'h00;
    logic              d1_res_valid;
    logic [0:0]        d1_res_idx;
    logic [7:0]        d1_res_data;
    logic              d1_res_ack = 1'b0;
    logic [DATA_W-1:0] mem1 [T1+N1];

    knn_ctrl #(.DATA_W(DATA_W), .NBR_TESTP(T1), .NBR_DATAP(N1), .ADDR_W(ADDR_W), .DIST_LAT(DL)) u_dut1 (
        .clk(clk), .rst(rst), .start(d1_start), .busy(d1_busy), .done(d1_done),
        .mem_req(d1_mem_req), .mem_addr(d1_mem_addr), .mem_rdata(d1_mem_rdata),
        .core_en(d1_core_en), .core_clr(d1_core_clr), .core_valid(d1_core_valid),
        .core_ready(d1_core_ready), .core_A(d1_core_A), .core_B(d1_core_B),
        .core_info(d1_core_info), .res_valid(d1_res_valid), .res_idx(d1_res_idx),
        .res_data(d1_res_data), .res_ack(d1_res_ack)
    );

    always @(posedge clk) begin
        if (d1_mem_req && int'(d1_mem_addr) < T1 + N1) d1_mem_rdata <= mem1[d1_mem_addr];
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vec++; if ({d0_busy, d0_done, d0_core_en, d0_core_clr} !== 4'b0000) begin
            errs++; $display("FAIL reset_ctrl: busy/done/en/clr=%b want 0000", {d0_busy, d0_done, d0_core_en, d0_core_clr}); end
        vec++; if ({d0_mem_req, d0_mem_addr} !== 9'd0) begin
            errs++; $display("FAIL reset_mem: req=%b addr=%0d want 0/0", d0_mem_req, d0_mem_addr); end
        vec++; if ({d0_core_valid, d0_core_ready, d0_res_valid} !== 3'b000) begin
            errs++; $display("FAIL reset_valid: valid/ready/res_valid=%b want 000", {d0_core_valid, d0_core_ready, d0_res_valid}); end
        vec++; if ({d0_core_A, d0_core_B} !== 64'd0) begin
            errs++; $display("FAIL reset_ops: A=%h B=%h want 0", d0_core_A, d0_core_B); end
        vec++; if ({d0_res_idx, d0_res_data} !== 10'd0) begin
            errs++; $display("FAIL reset_res: idx=%0d data=%h want 0", d0_res_idx, d0_res_data); end
        rst = 1'b1;
        @(negedge clk);
        vec++; if ({d0_busy, d1_busy, d0_core_clr, d1_core_clr} !== 4'b0000) begin
            errs++; $display("FAIL reset_idle: busy0/busy1/clr0/clr1=%b want 0000", {d0_busy, d1_busy, d0_core_clr, d1_core_clr}); end
        $display("test_reset done");
    endtask

    // Full run with immediate ack against a per-cycle timeline model.
    task automatic test_basic();
        int p, o, exp_addr;
        logic eb, ed, ec, er, ev, ey, es;
        logic [7:0] got, exp;
        for (int i = 0; i < T0 + N0; i++) mem0[i] = $urandom;
        d0_core_info = 8'h5A;
        @(negedge clk);
        d0_start = 1'b1;
        @(negedge clk);
        d0_start = 1'b0;
        for (int k = 1; k <= T0 * PER0 + 1; k++) begin
            p  = (k - 1) / PER0;
            o  = (k - 1) % PER0;
            eb = (k <= T0 * PER0);
            ed = (k == T0 * PER0 + 1);
            ec = eb && (o == 0);
            er = eb && (o == 1 || (o >= 3 && o < 3 + N0));
            ev = eb && (o >= 4 && o <= N0 + 3);
            ey = eb && (o >= 3 && o < 3 + N0 + DL + 2);
            es = eb && (o == PER0 - 1);
            exp_addr = (o == 1) ? p : T0 + o - 3;
            got = {d0_busy, d0_done, d0_core_en, d0_core_clr, d0_mem_req, d0_core_valid, d0_core_ready, d0_res_valid};
            exp = {eb, ed, eb, ec, er, ev, ey, es};
            vec++; if (got !== exp) begin
                errs++; $display("FAIL basic_ctrl cyc=%0d: busy,done,en,clr,req,valid,ready,res=%b want %b", k, got, exp); end
            if (er) begin
                vec++; if (d0_mem_addr !== ADDR_W'(exp_addr)) begin
                    errs++; $display("FAIL basic_addr cyc=%0d: addr=%0d want %0d", k, d0_mem_addr, exp_addr); end
            end
            if (ev) begin
                vec++; if (d0_core_B !== mem0[T0 + o - 4] || d0_core_A !== mem0[p]) begin
                    errs++; $display("FAIL basic_ops cyc=%0d: A=%h B=%h want A=%h B=%h", k, d0_core_A, d0_core_B, mem0[p], mem0[T0 + o - 4]); end
            end
            if (es) begin
                vec++; if (d0_res_idx !== 2'(p) || d0_res_data !== 8'h5A) begin
                    errs++; $display("FAIL basic_res cyc=%0d: idx=%0d data=%h want idx=%0d data=5a", k, d0_res_idx, d0_res_data, p); end
            end
            d0_res_ack = d0_res_valid;
            @(negedge clk);
        end
        d0_res_ack = 1'b0;
        $display("test_basic done");
    endtask

    // Result for test point 1 held for 7 cycles without ack.
    task automatic test_ack_stall();
        logic [7:0] cap, newinfo;
        logic found, ok;
        cap = 8'($urandom);
        newinfo = cap ^ 8'hFF;
        d0_core_info = cap;
        @(negedge clk);
        d0_start = 1'b1;
        @(negedge clk);
        d0_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (d0_res_valid && d0_res_idx == 2'd1) begin found = 1'b1; break; end
            d0_res_ack = d0_res_valid;
            @(negedge clk);
        end
        d0_res_ack = 1'b0;
        vec++; if (!found) begin errs++; $display("FAIL stall_wait: res idx 1 seen=%b want 1", found); end
        d0_core_info = newinfo;
        for (int w = 0; w < 8; w++) begin
            vec++; if ({d0_res_valid, d0_res_idx, d0_res_data} !== {1'b1, 2'd1, cap}) begin
                errs++; $display("FAIL stall_hold w=%0d: valid=%b idx=%0d data=%h want 1/1/%h", w, d0_res_valid, d0_res_idx, d0_res_data, cap); end
            vec++; if ({d0_core_clr, d0_mem_req} !== 2'b00) begin
                errs++; $display("FAIL stall_quiet w=%0d: clr/req=%b want 00", w, {d0_core_clr, d0_mem_req}); end
            if (w == 7) d0_res_ack = 1'b1;
            @(negedge clk);
        end
        d0_res_ack = 1'b0;
        vec++; if ({d0_res_valid, d0_core_clr} !== 2'b01) begin
            errs++; $display("FAIL stall_resume: res_valid/clr=%b want 01", {d0_res_valid, d0_core_clr}); end
        @(negedge clk);
        vec++; if ({d0_mem_req, d0_mem_addr} !== {1'b1, 8'd2}) begin
            errs++; $display("FAIL stall_ld: req=%b addr=%0d want 1/2", d0_mem_req, d0_mem_addr); end
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (d0_res_valid && d0_res_idx == 2'd2) begin
                vec++; if (d0_res_data !== newinfo) begin
                    errs++; $display("FAIL stall_next: data=%h want %h", d0_res_data, newinfo); end
            end
            if (d0_done) begin ok = 1'b1; break; end
            d0_res_ack = d0_res_valid;
            @(negedge clk);
        end
        d0_res_ack = 1'b0;
        vec++; if (!ok) begin errs++; $display("FAIL stall_done: done seen=%b want 1", ok); end
        $display("test_ack_stall done");
    endtask

    // start in STREAM and in DONE ignored; start right after done runs again.
    task automatic test_start_ignored();
        int nclr, nres, kdone;
        logic pulsed, ok;
        d0_core_info = 8'($urandom);
        @(negedge clk);
        d0_start = 1'b1;
        @(negedge clk);
        d0_start = 1'b0;
        nclr = 0; pulsed = 1'b0; kdone = 0;
        for (int k = 1; k < 200; k++) begin
            if (d0_core_clr) nclr++;
            if (d0_done) begin kdone = k; break; end
            d0_res_ack = d0_res_valid;
            d0_start   = !pulsed && d0_mem_req && d0_core_ready;
            if (d0_start) pulsed = 1'b1;
            @(negedge clk);
        end
        d0_res_ack = 1'b0;
        vec++; if (nclr != T0 || kdone != T0 * PER0 + 1) begin
            errs++; $display("FAIL start_stream: clr=%0d done_cyc=%0d want %0d/%0d", nclr, kdone, T0, T0 * PER0 + 1); end
        d0_start = 1'b1;
        @(negedge clk);
        vec++; if ({d0_busy, d0_core_clr} !== 2'b00) begin
            errs++; $display("FAIL start_done: busy/clr=%b want 00", {d0_busy, d0_core_clr}); end
        @(negedge clk);
        d0_start = 1'b0;
        vec++; if ({d0_busy, d0_core_clr} !== 2'b11) begin
            errs++; $display("FAIL start_again: busy/clr=%b want 11", {d0_busy, d0_core_clr}); end
        nres = 0; ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (d0_res_valid) nres++;
            if (d0_done) begin ok = 1'b1; break; end
            d0_res_ack = d0_res_valid;
            @(negedge clk);
        end
        d0_res_ack = 1'b0;
        vec++; if (!ok || nres != T0) begin
            errs++; $display("FAIL start_rerun: done=%b results=%0d want 1/%0d", ok, nres, T0); end
        $display("test_start_ignored done");
    endtask

    // One test point, one data point.
    task automatic test_small();
        int nvalid, nres, kdone;
        logic [7:0] info;
        for (int i = 0; i < T1 + N1; i++) mem1[i] = $urandom;
        info = 8'($urandom);
        d1_core_info = info;
        @(negedge clk);
        d1_start = 1'b1;
        @(negedge clk);
        d1_start = 1'b0;
        nvalid = 0; nres = 0; kdone = 0;
        for (int k = 1; k <= PER1 + 3; k++) begin
            if (d1_core_valid) begin
                nvalid++;
                vec++; if (d1_core_B !== mem1[1] || d1_core_A !== mem1[0]) begin
                    errs++; $display("FAIL small_ops: A=%h B=%h want %h/%h", d1_core_A, d1_core_B, mem1[0], mem1[1]); end
            end
            if (d1_res_valid) begin
                nres++;
                vec++; if (d1_res_data !== info || d1_res_idx !== 1'b0) begin
                    errs++; $display("FAIL small_res: data=%h idx=%0d want %h/0", d1_res_data, d1_res_idx, info); end
            end
            if (d1_done && kdone == 0) kdone = k;
            d1_res_ack = d1_res_valid;
            @(negedge clk);
        end
        d1_res_ack = 1'b0;
        vec++; if (nvalid != 1 || nres != 1 || kdone != PER1 + 1) begin
            errs++; $display("FAIL small_count: valid=%0d res=%0d done_cyc=%0d want 1/1/%0d", nvalid, nres, kdone, PER1 + 1); end
        $display("test_small done");
    endtask

    // Asynchronous reset during DRAIN of test point 2, then a fresh run.
    task automatic test_reset_mid();
        int nclr, nres, first_idx;
        logic hit, ok;
        d0_core_info = 8'($urandom);
        @(negedge clk);
        d0_start = 1'b1;
        @(negedge clk);
        d0_start = 1'b0;
        nclr = 0; hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (d0_core_clr) nclr++;
            if (nclr == 3 && d0_core_ready && !d0_mem_req) begin hit = 1'b1; break; end
            d0_res_ack = d0_res_valid;
            @(negedge clk);
        end
        d0_res_ack = 1'b0;
        vec++; if (!hit) begin errs++; $display("FAIL rstmid_wait: drain of tp2 seen=%b want 1", hit); end
        #2 rst = 1'b0;
        #1;
        vec++; if ({d0_busy, d0_core_en, d0_core_valid, d0_core_ready, d0_res_valid, d0_mem_req} !== 6'd0) begin
            errs++; $display("FAIL rstmid_async: busy,en,valid,ready,res,req=%b want 000000",
                             {d0_busy, d0_core_en, d0_core_valid, d0_core_ready, d0_res_valid, d0_mem_req}); end
        vec++; if ({d0_core_A, d0_core_B, d0_res_data} !== 72'd0) begin
            errs++; $display("FAIL rstmid_data: A=%h B=%h res=%h want 0", d0_core_A, d0_core_B, d0_res_data); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vec++; if ({d0_busy, d0_core_clr} !== 2'b00) begin
            errs++; $display("FAIL rstmid_idle: busy/clr=%b want 00", {d0_busy, d0_core_clr}); end
        d0_start = 1'b1;
        @(negedge clk);
        d0_start = 1'b0;
        vec++; if (d0_core_clr !== 1'b1) begin errs++; $display("FAIL rstmid_clr: clr=%b want 1", d0_core_clr); end
        @(negedge clk);
        vec++; if ({d0_mem_req, d0_mem_addr} !== {1'b1, 8'd0}) begin
            errs++; $display("FAIL rstmid_ld: req=%b addr=%0d want 1/0", d0_mem_req, d0_mem_addr); end
        nres = 0; first_idx = -1; ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (d0_res_valid) begin
                if (first_idx < 0) first_idx = int'(d0_res_idx);
                nres++;
            end
            if (d0_done) begin ok = 1'b1; break; end
            d0_res_ack = d0_res_valid;
            @(negedge clk);
        end
        d0_res_ack = 1'b0;
        vec++; if (!ok || nres != T0 || first_idx != 0) begin
            errs++; $display("FAIL rstmid_rerun: done=%b results=%0d first_idx=%0d want 1/%0d/0", ok, nres, first_idx, T0); end
        $display("test_reset_mid done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_ack_stall();
        test_start_ignored();
        test_small();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
